// File: rtl/ecc_scalar_mul_ctrl_pkg.sv
// Shared definitions for the ECC scalar-multiplication sequencer.
// The coordinate width and state type are shared with the point-operation units.
package ecc_scalar_mul_ctrl_pkg;

  localparam int MAX_BITS = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DBL_ISSUE = 3'd1,
    S_DBL_WAIT  = 3'd2,
    S_ADD_ISSUE = 3'd3,
    S_ADD_WAIT  = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } ecc_state_e;

endpackage

// File: rtl/ecc_scalar_mul_ctrl.sv
// Left-to-right double-and-add sequencer for Q = k*P.
// The point at infinity (x all ones) is resolved locally and never sent to the point units.
module ecc_scalar_mul_ctrl
  import ecc_scalar_mul_ctrl_pkg::*;
#(
  parameter int W  = MAX_BITS,
  parameter int NB = $clog2(W + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [W-1:0]  i_k,
  input  logic [NB-1:0] i_nbits,
  input  logic [W-1:0]  i_px,
  input  logic [W-1:0]  i_py,
  output logic          o_busy,
  output logic          o_finish,
  output logic [W-1:0]  o_rx,
  output logic [W-1:0]  o_ry,
  output logic          o_dbl_start,
  output logic [W-1:0]  o_dbl_x,
  output logic [W-1:0]  o_dbl_y,
  input  logic          i_dbl_finish,
  input  logic [W-1:0]  i_dbl_x,
  input  logic [W-1:0]  i_dbl_y,
  output logic          o_add_start,
  output logic [W-1:0]  o_add_x1,
  output logic [W-1:0]  o_add_y1,
  output logic [W-1:0]  o_add_x2,
  output logic [W-1:0]  o_add_y2,
  input  logic          i_add_finish,
  input  logic [W-1:0]  i_add_x,
  input  logic [W-1:0]  i_add_y
);

  localparam int            IW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [NB-1:0] W_NB = NB'(W);

  ecc_state_e    state_q, state_d;
  logic [W-1:0]  k_q, k_d;
  logic [W-1:0]  px_q, px_d;
  logic [W-1:0]  py_q, py_d;
  logic [W-1:0]  r_x_q, r_x_d;
  logic [W-1:0]  r_y_q, r_y_d;
  logic [IW-1:0] idx_q, idx_d;

  logic          busy_q, busy_d;
  logic          finish_q, finish_d;
  logic [W-1:0]  rx_out_q, rx_out_d;
  logic [W-1:0]  ry_out_q, ry_out_d;
  logic          dbl_start_q, dbl_start_d;
  logic [W-1:0]  dbl_x_q, dbl_x_d;
  logic [W-1:0]  dbl_y_q, dbl_y_d;
  logic          add_start_q, add_start_d;
  logic [W-1:0]  add_x1_q, add_x1_d;
  logic [W-1:0]  add_y1_q, add_y1_d;
  logic [W-1:0]  add_x2_q, add_x2_d;
  logic [W-1:0]  add_y2_q, add_y2_d;

  logic [NB-1:0] n_clamp;
  logic          r_inf;
  logic          k_bit;

  assign n_clamp = (i_nbits > W_NB) ? W_NB : i_nbits;
  assign r_inf   = &r_x_q;
  assign k_bit   = k_q[idx_q];

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    px_d        = px_q;
    py_d        = py_q;
    r_x_d       = r_x_q;
    r_y_d       = r_y_q;
    idx_d       = idx_q;
    finish_d    = 1'b0;
    rx_out_d    = rx_out_q;
    ry_out_d    = ry_out_q;
    dbl_start_d = 1'b0;
    dbl_x_d     = dbl_x_q;
    dbl_y_d     = dbl_y_q;
    add_start_d = 1'b0;
    add_x1_d    = add_x1_q;
    add_y1_d    = add_y1_q;
    add_x2_d    = add_x2_q;
    add_y2_d    = add_y2_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          k_d   = i_k;
          px_d  = i_px;
          py_d  = i_py;
          r_x_d = '1;
          r_y_d = '1;
          idx_d = IW'(n_clamp - NB'(1));
          state_d = (n_clamp == '0) ? S_DONE : S_DBL_ISSUE;
        end
      end

      S_DBL_ISSUE: begin
        if (r_inf) begin
          state_d = S_ADD_ISSUE;
        end else begin
          dbl_x_d     = r_x_q;
          dbl_y_d     = r_y_q;
          dbl_start_d = 1'b1;
          state_d     = S_DBL_WAIT;
        end
      end

      S_DBL_WAIT: begin
        if (i_dbl_finish) begin
          r_x_d   = i_dbl_x;
          r_y_d   = i_dbl_y;
          state_d = S_ADD_ISSUE;
        end
      end

      // INF + P needs no unit: the sum is simply P.
      S_ADD_ISSUE: begin
        if (!k_bit) begin
          state_d = S_NEXT;
        end else if (r_inf) begin
          r_x_d   = px_q;
          r_y_d   = py_q;
          state_d = S_NEXT;
        end else begin
          add_x1_d    = r_x_q;
          add_y1_d    = r_y_q;
          add_x2_d    = px_q;
          add_y2_d    = py_q;
          add_start_d = 1'b1;
          state_d     = S_ADD_WAIT;
        end
      end

      S_ADD_WAIT: begin
        if (i_add_finish) begin
          r_x_d   = i_add_x;
          r_y_d   = i_add_y;
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        if (idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = S_DBL_ISSUE;
        end
      end

      S_DONE: begin
        rx_out_d = r_x_q;
        ry_out_d = r_y_q;
        finish_d = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      px_q        <= '0;
      py_q        <= '0;
      r_x_q       <= '1;
      r_y_q       <= '1;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      rx_out_q    <= '1;
      ry_out_q    <= '1;
      dbl_start_q <= 1'b0;
      dbl_x_q     <= '0;
      dbl_y_q     <= '0;
      add_start_q <= 1'b0;
      add_x1_q    <= '0;
      add_y1_q    <= '0;
      add_x2_q    <= '0;
      add_y2_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      px_q        <= px_d;
      py_q        <= py_d;
      r_x_q       <= r_x_d;
      r_y_q       <= r_y_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      rx_out_q    <= rx_out_d;
      ry_out_q    <= ry_out_d;
      dbl_start_q <= dbl_start_d;
      dbl_x_q     <= dbl_x_d;
      dbl_y_q     <= dbl_y_d;
      add_start_q <= add_start_d;
      add_x1_q    <= add_x1_d;
      add_y1_q    <= add_y1_d;
      add_x2_q    <= add_x2_d;
      add_y2_q    <= add_y2_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_finish    = finish_q;
  assign o_rx        = rx_out_q;
  assign o_ry        = ry_out_q;
  assign o_dbl_start = dbl_start_q;
  assign o_dbl_x     = dbl_x_q;
  assign o_dbl_y     = dbl_y_q;
  assign o_add_start = add_start_q;
  assign o_add_x1    = add_x1_q;
  assign o_add_y1    = add_y1_q;
  assign o_add_x2    = add_x2_q;
  assign o_add_y2    = add_y2_q;

endmodule

// File: tb/tb_ecc_scalar_mul_ctrl.sv
// Scoreboard bench for ecc_scalar_mul_ctrl with stub doubling/addition units.
// Expected results, unit-call sequences and latencies come from a double-and-add reference model.
module tb_ecc_scalar_mul_ctrl;
  import ecc_scalar_mul_ctrl_pkg::*;

  localparam int            W         = MAX_BITS;
  localparam int            NB        = $clog2(W + 1);
  localparam int            STUB_WAIT = 4;
  localparam int            UNIT_LAT  = STUB_WAIT + 1;
  localparam logic [W-1:0]  INF_X     = '1;
  localparam logic [W-1:0]  NEG_MARK  = W'(16'h0F0F);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [W-1:0]  i_k;
  logic [NB-1:0] i_nbits;
  logic [W-1:0]  i_px, i_py;
  logic          o_busy, o_finish;
  logic [W-1:0]  o_rx, o_ry;
  logic          o_dbl_start;
  logic [W-1:0]  o_dbl_x, o_dbl_y;
  logic          i_dbl_finish;
  logic [W-1:0]  i_dbl_x, i_dbl_y;
  logic          o_add_start;
  logic [W-1:0]  o_add_x1, o_add_y1, o_add_x2, o_add_y2;
  logic          i_add_finish;
  logic [W-1:0]  i_add_x, i_add_y;

  logic dbl_fin_stub = 1'b0;
  logic add_fin_stub = 1'b0;
  logic spur_add     = 1'b0;

  assign i_dbl_finish = dbl_fin_stub;
  assign i_add_finish = add_fin_stub | spur_add;

  ecc_scalar_mul_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_start      (i_start),
    .i_k          (i_k),
    .i_nbits      (i_nbits),
    .i_px         (i_px),
    .i_py         (i_py),
    .o_busy       (o_busy),
    .o_finish     (o_finish),
    .o_rx         (o_rx),
    .o_ry         (o_ry),
    .o_dbl_start  (o_dbl_start),
    .o_dbl_x      (o_dbl_x),
    .o_dbl_y      (o_dbl_y),
    .i_dbl_finish (i_dbl_finish),
    .i_dbl_x      (i_dbl_x),
    .i_dbl_y      (i_dbl_y),
    .o_add_start  (o_add_start),
    .o_add_x1     (o_add_x1),
    .o_add_y1     (o_add_y1),
    .o_add_x2     (o_add_x2),
    .o_add_y2     (o_add_y2),
    .i_add_finish (i_add_finish),
    .i_add_x      (i_add_x),
    .i_add_y      (i_add_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_add;
    logic [W-1:0] x1, y1, x2, y2;
  } op_t;

  typedef struct {
    logic [W-1:0] rx, ry;
    int           lat;
    int           start_cyc;
  } res_t;

  op_t  op_q[$];
  res_t sb_q[$];
  op_t  mon_o;
  res_t mon_r;

  int n_checks  = 0;
  int n_pass    = 0;
  int cyc       = 0;
  int rst_epoch = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub unit behaviour; the reference model uses the same token rules.
  function automatic void dbl_tok(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] ox, output logic [W-1:0] oy);
    ox = (x << 1) ^ y ^ W'(16'h00A5);
    oy = y + x + W'(3);
  endfunction

  function automatic void add_tok(input logic [W-1:0] x1, input logic [W-1:0] y1,
                                  input logic [W-1:0] x2, input logic [W-1:0] y2,
                                  output logic [W-1:0] ox, output logic [W-1:0] oy);
    ox = (x2 == NEG_MARK) ? INF_X : (x1 + x2 + W'(7));
    oy = y1 ^ y2 ^ W'(16'h5A5A);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: plain double-and-add over the scalar bits, then pulse the start.
  task automatic applyStimulus(input logic [W-1:0] k, input int nb,
                               input logic [W-1:0] px, input logic [W-1:0] py);
    logic [W-1:0] rx, ry;
    int n, nops;
    op_t  o;
    res_t r;
    n    = (nb > W) ? W : nb;
    rx   = INF_X;
    ry   = INF_X;
    nops = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (rx != INF_X) begin
        o.is_add = 1'b0; o.x1 = rx; o.y1 = ry; o.x2 = '0; o.y2 = '0;
        op_q.push_back(o);
        dbl_tok(rx, ry, rx, ry);
        nops++;
      end
      if (k[i]) begin
        if (rx == INF_X) begin
          rx = px;
          ry = py;
        end else begin
          o.is_add = 1'b1; o.x1 = rx; o.y1 = ry; o.x2 = px; o.y2 = py;
          op_q.push_back(o);
          add_tok(rx, ry, px, py, rx, ry);
          nops++;
        end
      end
    end
    r.rx        = rx;
    r.ry        = ry;
    r.lat       = 3 * n + 2 + UNIT_LAT * nops;
    r.start_cyc = cyc;
    sb_q.push_back(r);
    i_k     = k;
    i_nbits = NB'(nb);
    i_px    = px;
    i_py    = py;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    checkOutput("busy_after_start", 64'(o_busy), 64'(1));
  endtask

  task automatic waitFinish();
    int c = 0;
    while (o_finish !== 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    checkOutput("finish_seen", 64'(o_finish), 64'(1));
  endtask

  task automatic waitPulse(input bit want_add);
    int c = 0;
    while (((want_add ? o_add_start : o_dbl_start) !== 1'b1) && c < 500) begin
      @(negedge clk);
      c++;
    end
    checkOutput(want_add ? "add_pulse_seen" : "dbl_pulse_seen",
                64'(want_add ? o_add_start : o_dbl_start), 64'(1));
  endtask

  task automatic checkResetValues();
    checkOutput("rst_busy",      64'(o_busy),      64'(0));
    checkOutput("rst_finish",    64'(o_finish),    64'(0));
    checkOutput("rst_dbl_start", 64'(o_dbl_start), 64'(0));
    checkOutput("rst_add_start", 64'(o_add_start), 64'(0));
    checkOutput("rst_rx",        64'(o_rx),        64'(INF_X));
    checkOutput("rst_ry",        64'(o_ry),        64'(INF_X));
    checkOutput("rst_dbl_ops",   64'({o_dbl_x, o_dbl_y}), 64'(0));
    checkOutput("rst_add_ops",   64'({o_add_x1, o_add_y1, o_add_x2, o_add_y2}), 64'(0));
  endtask

  // Monitor: pops the scoreboard on every finish and the op queue on every unit start.
  always @(negedge clk) begin
    if (o_finish === 1'b1) begin
      checkOutput("finish_expected", 64'(sb_q.size() != 0), 64'(1));
      if (sb_q.size() != 0) begin
        mon_r = sb_q.pop_front();
        checkOutput("result_x", 64'(o_rx), 64'(mon_r.rx));
        if (mon_r.rx != INF_X) checkOutput("result_y", 64'(o_ry), 64'(mon_r.ry));
        checkOutput("latency", 64'(cyc - mon_r.start_cyc), 64'(mon_r.lat));
        checkOutput("busy_at_finish", 64'(o_busy), 64'(0));
      end
    end
    if (o_dbl_start === 1'b1 || o_add_start === 1'b1) begin
      checkOutput("single_unit_pulse", 64'(o_dbl_start & o_add_start), 64'(0));
      checkOutput("unit_start_expected", 64'(op_q.size() != 0), 64'(1));
      if (op_q.size() != 0) begin
        mon_o = op_q.pop_front();
        checkOutput("op_kind", 64'(o_add_start), 64'(mon_o.is_add));
        if (mon_o.is_add) begin
          checkOutput("add_r_operand", 64'({o_add_x1, o_add_y1}), 64'({mon_o.x1, mon_o.y1}));
          checkOutput("add_p_operand", 64'({o_add_x2, o_add_y2}), 64'({mon_o.x2, mon_o.y2}));
        end else begin
          checkOutput("dbl_operand", 64'({o_dbl_x, o_dbl_y}), 64'({mon_o.x1, mon_o.y1}));
        end
      end
    end
  end

  logic [W-1:0] sd_x, sd_y, sd_ox, sd_oy;
  int           sd_epoch;
  always begin
    @(negedge clk);
    if (o_dbl_start === 1'b1) begin
      sd_x = o_dbl_x; sd_y = o_dbl_y; sd_epoch = rst_epoch;
      repeat (STUB_WAIT) @(negedge clk);
      if (sd_epoch == rst_epoch)
        checkOutput("dbl_operand_hold", 64'({o_dbl_x, o_dbl_y}), 64'({sd_x, sd_y}));
      dbl_tok(sd_x, sd_y, sd_ox, sd_oy);
      i_dbl_x = sd_ox; i_dbl_y = sd_oy; dbl_fin_stub = 1'b1;
      @(negedge clk);
      dbl_fin_stub = 1'b0;
    end
  end

  logic [W-1:0] sa_x1, sa_y1, sa_x2, sa_y2, sa_ox, sa_oy;
  int           sa_epoch;
  always begin
    @(negedge clk);
    if (o_add_start === 1'b1) begin
      sa_x1 = o_add_x1; sa_y1 = o_add_y1; sa_x2 = o_add_x2; sa_y2 = o_add_y2;
      sa_epoch = rst_epoch;
      repeat (STUB_WAIT) @(negedge clk);
      if (sa_epoch == rst_epoch)
        checkOutput("add_operand_hold", 64'({o_add_x1, o_add_y1, o_add_x2, o_add_y2}),
                    64'({sa_x1, sa_y1, sa_x2, sa_y2}));
      add_tok(sa_x1, sa_y1, sa_x2, sa_y2, sa_ox, sa_oy);
      i_add_x = sa_ox; i_add_y = sa_oy; add_fin_stub = 1'b1;
      @(negedge clk);
      add_fin_stub = 1'b0;
    end
  end

  initial begin
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_k     = '0;
    i_nbits = '0;
    i_px    = '0;
    i_py    = '0;
    i_dbl_x = '0;
    i_dbl_y = '0;
    i_add_x = '0;
    i_add_y = '0;
    repeat (3) @(negedge clk);
    checkResetValues();
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases; each start is issued in the cycle the previous finish is seen.
    applyStimulus(W'(0), 8, W'(5), W'(7));            waitFinish();
    applyStimulus(W'(1), 1, W'(5), W'(7));            waitFinish();
    applyStimulus(W'(2), 2, W'(5), W'(7));            waitFinish();
    applyStimulus(W'(3), 2, W'(5), W'(7));            waitFinish();
    applyStimulus(W'(16'hFFFF), 0, W'(5), W'(7));     waitFinish();
    applyStimulus(W'(16'h8001), 31, W'(9), W'(4));    waitFinish();
    applyStimulus(W'(6), 3, NEG_MARK, W'(9));         waitFinish();
    applyStimulus(W'(16'hB00D), 16, W'(16'h1234), W'(16'h4321)); waitFinish();

    // Start and a stray add-finish while the doubler is working are both ignored.
    applyStimulus(W'(2), 2, W'(5), W'(7));
    waitPulse(1'b0);
    @(negedge clk);
    i_start  = 1'b1;
    i_k      = W'(16'hFFFF);
    i_nbits  = NB'(16);
    spur_add = 1'b1;
    @(negedge clk);
    i_start  = 1'b0;
    spur_add = 1'b0;
    waitFinish();
    repeat (12) @(negedge clk);

    // Reset while the adder is busy; its late finish must not disturb anything.
    applyStimulus(W'(3), 2, W'(5), W'(7));
    waitPulse(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    rst_epoch++;
    sb_q.delete();
    op_q.delete();
    #1;
    checkResetValues();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("idle_after_late_finish", 64'(o_busy), 64'(0));
    checkOutput("rx_after_late_finish", 64'(o_rx), 64'(INF_X));
    applyStimulus(W'(3), 2, W'(5), W'(7));            waitFinish();

    // Randomized runs, some back-to-back and some with idle gaps.
    for (int t = 0; t < 40; t++) begin
      applyStimulus(W'($urandom), int'($urandom_range(0, (1 << NB) - 1)),
                    W'($urandom), W'($urandom));
      waitFinish();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    repeat (30) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    checkOutput("op_queue_drained", 64'(op_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
